// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared register-file widths, constants and arbiter state type
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2 : stateless two-way round-robin grant (index 0 = A, 1 = B)
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On contention the requester that was not granted last wins.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// regfile_write_arbiter : shares the register-file write port between two
// requesters with round-robin fairness and a post-reset clear of x1..x31.
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int INIT_CLEAR = 1,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DATA_W     = REG_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              WE3,
  output logic [ADDR_W-1:0] WA3,
  output logic [DATA_W-1:0] WD3,
  output logic              clear_done,
  output logic              last_grant
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic              run;
  logic [1:0]        req;
  logic [1:0]        gnt;

  assign run = (state_q == ST_RUN);
  assign req = {b_valid, a_valid} & {2{run}};

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_grant_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    wa_d         = wa_q;
    wd_d         = wd_q;

    if (state_q == ST_CLEAR) begin
      we_d      = 1'b1;
      wa_d      = clr_idx_q;
      wd_d      = '0;
      clr_idx_d = clr_idx_q + ADDR_W'(1);
      if (clr_idx_q == LAST_IDX) begin
        state_d = ST_RUN;
      end
    end else if (gnt[0]) begin
      // Writes to x0 still complete the handshake but never reach the port.
      last_grant_d = 1'b0;
      if (a_addr != ZERO_ADDR) begin
        we_d = 1'b1;
        wa_d = a_addr;
        wd_d = a_data;
      end
    end else if (gnt[1]) begin
      last_grant_d = 1'b1;
      if (b_addr != ZERO_ADDR) begin
        we_d = 1'b1;
        wa_d = b_addr;
        wd_d = b_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
      clr_idx_q    <= ADDR_W'(1);
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
    end
  end

  assign a_ready    = gnt[0];
  assign b_ready    = gnt[1];
  assign WE3        = we_q;
  assign WA3        = wa_q;
  assign WD3        = wd_q;
  assign clear_done = run;
  assign last_grant = last_grant_q;

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (WE3/WA3/WD3) between two requesters: A, the core writeback, and B, the debug/load unit.
- Uses a valid/ready handshake per requester, with round-robin fairness between them.
- After reset, sequences a hardware clear of x1..x31 to zero, because the register file itself has no reset.
- Sits between the writeback/debug sources and Register_File; all write-port outputs are registered.

Parameters:
- INIT_CLEAR, 1: 1 = run the post-reset clear sequence; 0 = go straight to RUN.
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A's write is accepted this cycle.
- a_addr  in  ADDR_W  A's destination register.
- a_data  in  DATA_W  A's write data.
- b_valid  in  1  requester B has a write pending.
- b_ready  out  1  B's write is accepted this cycle.
- b_addr  in  ADDR_W  B's destination register.
- b_data  in  DATA_W  B's write data.
- WE3  out  1  register file write enable (registered).
- WA3  out  ADDR_W  register file write address (registered).
- WD3  out  DATA_W  register file write data (registered).
- clear_done  out  1  high in RUN state.
- last_grant  out  1  0 = A, 1 = B; the requester granted most recently.

Behaviour:
- Reset (reset=1 at a rising edge):
  - WE3=0, WA3=0, WD3=0, last_grant=1, so A has priority first.
  - State = CLEAR and clr_idx=1 if INIT_CLEAR=1; otherwise state = RUN.
  - Any write already registered on the port is dropped.
- States:
  - CLEAR: a_ready=b_ready=0 and clear_done=0.
    - Each edge registers WE3=1, WA3=clr_idx, WD3=0, then clr_idx increments.
    - The edge that registers clr_idx=31 also moves the state to RUN.
    - Result: WA3 shows 1..31 on 31 consecutive cycles, with no gaps.
  - RUN: clear_done=1. There is no transition back except via reset.
  - Reset asserted mid-CLEAR restarts the sequence at x1.
- Grant (RUN only, combinational from the valids and last_grant):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant; last_grant holds.
  - x_ready = grant_x. A handshake completes when x_valid && x_ready.
  - ready never depends on the register-file side. There is no backpressure: one write is accepted per cycle.
  - On a grant, last_grant <= the granted requester.
- Write issue:
  - A handshake in cycle N gives registered WE3/WA3/WD3 in cycle N+1, i.e. latency 1.
  - With no handshake in cycle N, WE3=0 in N+1. WA3/WD3 hold their previous values.
- x0 writes:
  - The handshake still completes and round-robin still advances.
  - WE3 stays 0 in N+1.
- Same-address requests from A and B in the same cycle: only the granted request is written. The other stays pending, so it is written in a later cycle and wins.
- Requester rule: a requester must hold valid, addr and data stable until ready. The block does not check this.
- No combinational path exists from the valids to WE3, WA3 or WD3.

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - Constant ZERO_REG=0.
  - arb_state_t enum {ST_CLEAR, ST_RUN}.
- One natural sub-module: rr_arb2, a stateless 2-way round-robin grant.
  - Inputs: req[1:0], last.
  - Output: gnt[1:0].
- The parent owns the state machine, clr_idx, last_grant and the output registers.

Test Plan:
1. INIT_CLEAR=1; hold reset 2 cycles, then release.
   - WE3=1 with WA3=1..31 on consecutive cycles and WD3=0 throughout.
   - Ready stays 0 until clear_done=1. clear_done rises in the cycle WA3=31 is shown.
   - The following cycle WE3=0 (no requesters).
2. RUN; a_valid only, addr=5, data=0xDEADBEEF for 1 cycle.
   - a_ready=1 that cycle.
   - Next cycle WE3=1, WA3=5, WD3=0xDEADBEEF.
   - Cycle after that WE3=0.
3. RUN from reset; A(addr 3, 0x11) and B(addr 4, 0x22) both valid continuously for 4 requests each.
   - Grants alternate A,B,A,B...
   - WA3 sequence is 3,4,3,4... and each requester sees exactly 50% acceptance.
4. RUN; b_valid, addr=0, data=0xFFFFFFFF.
   - b_ready=1 and last_grant=1.
   - Next cycle WE3=0.
5. Assert reset at the 10th clear cycle (WA3=10); hold 1 cycle; release.
   - WE3=0 after the reset edge.
   - The sequence restarts at WA3=1 and completes all 31 addresses.
6. INIT_CLEAR=0; release reset with a_valid (addr 7, 0x5A) asserted.
   - a_ready=1 in the first cycle after release.
   - Next cycle WE3=1, WA3=7, WD3=0x5A, and clear_done=1 throughout.
